// File: rtl/regfile_2r1w.sv
// Two-read/one-write register file with optional write-to-read bypass.
// After reset a clear sequencer zeroes every entry while busy is held high.
module regfile_2r1w #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3,
    parameter bit BYPASS = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] write_addr,
    input  logic [DATA_W-1:0] data,
    input  logic              re_a,
    input  logic [ADDR_W-1:0] read_addr_a,
    output logic [DATA_W-1:0] q_a,
    input  logic              re_b,
    input  logic [ADDR_W-1:0] read_addr_b,
    output logic [DATA_W-1:0] q_b,
    output logic              busy
);

    localparam int                DEPTH    = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(DEPTH - 1);
    localparam logic [DATA_W-1:0] ZERO_D   = {DATA_W{1'b0}};
    localparam logic [ADDR_W-1:0] ZERO_A   = {ADDR_W{1'b0}};

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_e;

    state_e            state_q,   state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic              busy_q,    busy_d;
    logic [DATA_W-1:0] q_a_q,     q_a_d;
    logic [DATA_W-1:0] q_b_q,     q_b_d;

    logic              ram_we_s;
    logic [ADDR_W-1:0] ram_waddr_s;
    logic [DATA_W-1:0] ram_wdata_s;
    logic [DATA_W-1:0] ram_q [DEPTH];

    // Next value of one read port: hold when disabled, forward write data on a bypass hit.
    function automatic logic [DATA_W-1:0] port_read(
        input logic              re,
        input logic              hit,
        input logic [DATA_W-1:0] mem_dat,
        input logic [DATA_W-1:0] wr_dat,
        input logic [DATA_W-1:0] hold
    );
        logic [DATA_W-1:0] res;
        if (!re) begin
            res = hold;
        end else if ((BYPASS == 1'b1) && hit) begin
            res = wr_dat;
        end else begin
            res = mem_dat;
        end
        return res;
    endfunction

    // Sequencer next-state, RAM write port selection and read-port next values.
    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        busy_d      = busy_q;
        q_a_d       = q_a_q;
        q_b_d       = q_b_q;
        ram_we_s    = 1'b0;
        ram_waddr_s = write_addr;
        ram_wdata_s = data;

        case (state_q)
            ST_CLEAR: begin
                ram_we_s    = 1'b1;
                ram_waddr_s = clr_cnt_q;
                ram_wdata_s = ZERO_D;
                q_a_d       = ZERO_D;
                q_b_d       = ZERO_D;
                // Leave on the last entry rather than wrapping the counter.
                if (clr_cnt_q == CLR_LAST) begin
                    state_d = ST_READY;
                    busy_d  = 1'b0;
                end else begin
                    clr_cnt_d = clr_cnt_q + ADDR_W'(1);
                    busy_d    = 1'b1;
                end
            end
            ST_READY: begin
                busy_d   = 1'b0;
                ram_we_s = we;
                q_a_d    = port_read(re_a, we && (read_addr_a == write_addr),
                                     ram_q[read_addr_a], data, q_a_q);
                q_b_d    = port_read(re_b, we && (read_addr_b == write_addr),
                                     ram_q[read_addr_b], data, q_b_q);
            end
            default: begin
                state_d   = ST_CLEAR;
                clr_cnt_d = ZERO_A;
                busy_d    = 1'b1;
                q_a_d     = ZERO_D;
                q_b_d     = ZERO_D;
            end
        endcase
    end

    // Control and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= ZERO_A;
            busy_q    <= 1'b1;
            q_a_q     <= ZERO_D;
            q_b_q     <= ZERO_D;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            busy_q    <= busy_d;
            q_a_q     <= q_a_d;
            q_b_q     <= q_b_d;
        end
    end

    // Storage array; contents are left untouched while reset is held.
    always_ff @(posedge clk) begin
        if (rst_n && ram_we_s) begin
            ram_q[ram_waddr_s] <= ram_wdata_s;
        end
    end

    assign q_a  = q_a_q;
    assign q_b  = q_b_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_regfile_2r1w.sv
// Bench for regfile_2r1w: bypass and non-bypass 8x8 instances share stimulus,
// a 16-bit/16-entry instance covers the scaled configuration.
module tb_regfile_2r1w;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        we, re_a, re_b;
    logic [2:0]  wa, ra_a, ra_b;
    logic [7:0]  d;
    logic [7:0]  qa, qb, qa_nb, qb_nb;
    logic        busy, busy_nb;

    logic        we_w, re_a_w, re_b_w;
    logic [3:0]  wa_w, ra_a_w, ra_b_w;
    logic [15:0] d_w, qa_w, qb_w;
    logic        busy_w;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    regfile_2r1w #(.DATA_W(8), .ADDR_W(3), .BYPASS(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .we(we), .write_addr(wa), .data(d),
        .re_a(re_a), .read_addr_a(ra_a), .q_a(qa),
        .re_b(re_b), .read_addr_b(ra_b), .q_b(qb), .busy(busy));

    regfile_2r1w #(.DATA_W(8), .ADDR_W(3), .BYPASS(1'b0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .we(we), .write_addr(wa), .data(d),
        .re_a(re_a), .read_addr_a(ra_a), .q_a(qa_nb),
        .re_b(re_b), .read_addr_b(ra_b), .q_b(qb_nb), .busy(busy_nb));

    regfile_2r1w #(.DATA_W(16), .ADDR_W(4), .BYPASS(1'b1)) dut_w (
        .clk(clk), .rst_n(rst_n), .we(we_w), .write_addr(wa_w), .data(d_w),
        .re_a(re_a_w), .read_addr_a(ra_a_w), .q_a(qa_w),
        .re_b(re_b_w), .read_addr_b(ra_b_w), .q_b(qb_w), .busy(busy_w));

    typedef struct {
        logic       we;
        logic [2:0] wa;
        logic [7:0] d;
        logic       re_a;
        logic [2:0] ra_a;
        logic       re_b;
        logic [2:0] ra_b;
        logic [7:0] qa;
        logic [7:0] qb;
        logic [7:0] qa_nb;
        logic [7:0] qb_nb;
    } vec_t;

    typedef struct {
        logic [7:0] qa;
        logic [7:0] qb;
        logic [7:0] qa_nb;
        logic [7:0] qb_nb;
    } exp_t;

    vec_t vecs [18];
    exp_t sb_q [$];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_main();
        we = 1'b0; wa = 3'd0; d = 8'h00;
        re_a = 1'b0; ra_a = 3'd0; re_b = 1'b0; ra_b = 3'd0;
    endtask

    task automatic idle_w();
        we_w = 1'b0; wa_w = 4'd0; d_w = 16'h0000;
        re_a_w = 1'b0; ra_a_w = 4'd0; re_b_w = 1'b0; ra_b_w = 4'd0;
    endtask

    // Runs a full post-release clear window; ops are offered and must be ignored.
    task automatic clear_window(input string tag);
        for (int i = 1; i <= 16; i++) begin
            if (i <= 8) begin
                we = 1'b1; wa = 3'd1; d = 8'hFF;
                re_a = 1'b1; ra_a = 3'd1; re_b = 1'b1; ra_b = 3'd1;
            end else begin
                idle_main();
            end
            we_w = 1'b1; wa_w = 4'd1; d_w = 16'hFFFF;
            re_a_w = 1'b1; ra_a_w = 4'd1; re_b_w = 1'b1; ra_b_w = 4'd1;
            step();
            check($sformatf("%s busy e%0d", tag, i), 16'(busy), 16'(i < 8));
            check($sformatf("%s busy_nb e%0d", tag, i), 16'(busy_nb), 16'(i < 8));
            check($sformatf("%s busy_w e%0d", tag, i), 16'(busy_w), 16'(i < 16));
            check($sformatf("%s qa_w e%0d", tag, i), qa_w, 16'h0000);
            if (i <= 8) begin
                check($sformatf("%s qa e%0d", tag, i), 16'(qa), 16'h0000);
                check($sformatf("%s qb e%0d", tag, i), 16'(qb), 16'h0000);
            end
        end
        idle_main();
        idle_w();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 4; k++)
            vecs[k] = '{1'b0, 3'd0, 8'h00, 1'b1, 3'(2*k), 1'b1, 3'(2*k+1), 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[4]  = '{1'b1, 3'd2, 8'hA5, 1'b0, 3'd0, 1'b0, 3'd0, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[5]  = '{1'b1, 3'd7, 8'h3C, 1'b0, 3'd0, 1'b0, 3'd0, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[6]  = '{1'b0, 3'd0, 8'h00, 1'b1, 3'd2, 1'b1, 3'd7, 8'hA5, 8'h3C, 8'hA5, 8'h3C};
        vecs[7]  = '{1'b1, 3'd4, 8'h11, 1'b0, 3'd0, 1'b0, 3'd0, 8'hA5, 8'h3C, 8'hA5, 8'h3C};
        vecs[8]  = '{1'b1, 3'd4, 8'h77, 1'b1, 3'd4, 1'b0, 3'd5, 8'h77, 8'h3C, 8'h11, 8'h3C};
        vecs[9]  = '{1'b0, 3'd0, 8'h00, 1'b1, 3'd4, 1'b0, 3'd0, 8'h77, 8'h3C, 8'h77, 8'h3C};
        vecs[10] = '{1'b1, 3'd3, 8'h5A, 1'b1, 3'd7, 1'b0, 3'd1, 8'h3C, 8'h3C, 8'h3C, 8'h3C};
        for (int k = 11; k < 15; k++)
            vecs[k] = '{1'b0, 3'd0, 8'h00, 1'b1, 3'd7, 1'b0, 3'(k-9), 8'h3C, 8'h3C, 8'h3C, 8'h3C};
        vecs[15] = '{1'b0, 3'd0, 8'h00, 1'b1, 3'd2, 1'b1, 3'd2, 8'hA5, 8'hA5, 8'hA5, 8'hA5};
        vecs[16] = '{1'b1, 3'd3, 8'hC3, 1'b1, 3'd3, 1'b1, 3'd3, 8'hC3, 8'hC3, 8'h5A, 8'h5A};
        vecs[17] = '{1'b0, 3'd0, 8'h00, 1'b1, 3'd3, 1'b1, 3'd6, 8'hC3, 8'h00, 8'hC3, 8'h00};

        rst_n = 1'b0;
        idle_main();
        idle_w();
        for (int i = 0; i < 3; i++) step();
        check("rst qa", 16'(qa), 16'h0000);
        check("rst qb", 16'(qb), 16'h0000);
        check("rst busy", 16'(busy), 16'h0001);
        check("rst busy_w", 16'(busy_w), 16'h0001);
        check("rst qb_w", qb_w, 16'h0000);

        rst_n = 1'b1;
        clear_window("clr");

        // Table vectors: expected results queued at drive time, checked one edge later.
        for (int i = 0; i < 18; i++) begin
            exp_t e;
            we = vecs[i].we; wa = vecs[i].wa; d = vecs[i].d;
            re_a = vecs[i].re_a; ra_a = vecs[i].ra_a;
            re_b = vecs[i].re_b; ra_b = vecs[i].ra_b;
            sb_q.push_back('{vecs[i].qa, vecs[i].qb, vecs[i].qa_nb, vecs[i].qb_nb});
            step();
            e = sb_q.pop_front();
            check($sformatf("vec%0d qa", i), 16'(qa), 16'(e.qa));
            check($sformatf("vec%0d qb", i), 16'(qb), 16'(e.qb));
            check($sformatf("vec%0d qa_nb", i), 16'(qa_nb), 16'(e.qa_nb));
            check($sformatf("vec%0d qb_nb", i), 16'(qb_nb), 16'(e.qb_nb));
        end
        idle_main();

        // Scaled configuration: cleared entry, write/read both ports, bypass.
        re_b_w = 1'b1; ra_b_w = 4'd1;
        step();
        check("w clr addr1", qb_w, 16'h0000);
        re_b_w = 1'b0;
        we_w = 1'b1; wa_w = 4'd15; d_w = 16'hBEEF;
        step();
        wa_w = 4'd7; d_w = 16'h1234;
        step();
        we_w = 1'b0;
        re_a_w = 1'b1; ra_a_w = 4'd15; re_b_w = 1'b1; ra_b_w = 4'd7;
        step();
        check("w rd qa", qa_w, 16'hBEEF);
        check("w rd qb", qb_w, 16'h1234);
        we_w = 1'b1; wa_w = 4'd15; d_w = 16'hCAFE; re_b_w = 1'b0; ra_b_w = 4'd15;
        step();
        check("w byp qa", qa_w, 16'hCAFE);
        check("w byp qb hold", qb_w, 16'h1234);
        idle_w();

        // Reset, then reset again at clear edge 4 to restart the sequence.
        rst_n = 1'b0;
        step();
        check("rst2 qa", 16'(qa), 16'h0000);
        check("rst2 busy", 16'(busy), 16'h0001);
        check("rst2 qa_w", qa_w, 16'h0000);
        rst_n = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            step();
            check($sformatf("mid busy e%0d", i), 16'(busy), 16'h0001);
        end
        rst_n = 1'b0;
        step();
        check("mid rst busy", 16'(busy), 16'h0001);
        rst_n = 1'b1;
        clear_window("reclr");

        re_a = 1'b1; ra_a = 3'd2; re_b = 1'b1; ra_b = 3'd4;
        re_a_w = 1'b1; ra_a_w = 4'd15; re_b_w = 1'b1; ra_b_w = 4'd7;
        step();
        check("lost qa", 16'(qa), 16'h0000);
        check("lost qb", 16'(qb), 16'h0000);
        check("lost qa_nb", 16'(qa_nb), 16'h0000);
        check("lost qa_w", qa_w, 16'h0000);
        check("lost qb_w", qb_w, 16'h0000);
        idle_main();
        idle_w();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_2r1w.md
# regfile_2r1w

Parametrised two-read/one-write register file for the RNBIP datapath, the successor to the 8×8 single-read register block. It adds width/depth parameters, a second independent read port, per-port read enables, optional same-cycle write-to-read bypass, and a reset-driven clear sequencer that zeroes every entry after reset. An 8-bit, 8-entry configuration is a drop-in superset of the existing register file, apart from the clear window.

## Interface
- `DATA_W`, 8: width of each entry and of the data ports.
- `ADDR_W`, 3: address width; `DEPTH` = 2**`ADDR_W` entries.
- `BYPASS`, 1: 1 forwards same-cycle write data to a matching read; 0 returns the old contents.
- `clk`  in  1  sole clock; all state changes on its rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `we`  in  1  write enable.
- `write_addr`  in  `ADDR_W`  write address.
- `data`  in  `DATA_W`  write data.
- `re_a`  in  1  read enable, port A.
- `read_addr_a`  in  `ADDR_W`  read address, port A.
- `q_a`  out  `DATA_W`  registered read data, port A.
- `re_b`  in  1  read enable, port B.
- `read_addr_b`  in  `ADDR_W`  read address, port B.
- `q_b`  out  `DATA_W`  registered read data, port B.
- `busy`  out  1  high while reset or clear is in progress; writes and reads are ignored.

## Operation
- States: CLEAR and READY. An internal clear counter `clr_cnt` is `ADDR_W` bits wide.
- Reset: any edge with `rst_n`=0 sets the state to CLEAR, `clr_cnt` to 0, `busy` to 1, and `q_a`/`q_b` to 0. RAM contents are not touched during reset.
- CLEAR, on each edge with `rst_n`=1:
  - `ram[clr_cnt]` <= 0 and `clr_cnt` increments.
  - When `clr_cnt` == `DEPTH`-1, the state moves to READY and `busy` <= 0.
  - `we`, `re_a` and `re_b` are ignored; `q_a` and `q_b` stay 0.
- READY, write: if `we`=1, `ram[write_addr]` <= `data`.
- READY, read on port x (A or B), evaluated independently:
  - If `re_x`=1: `q_x` <= `ram[read_addr_x]`.
  - Exception: if `BYPASS`=1, `we`=1 and `read_addr_x` == `write_addr`, then `q_x` <= `data`.
  - If `re_x`=0: `q_x` holds its value.
- Both ports may read the same address in the same cycle. Each returns an identical value.
- Reset asserted mid-CLEAR or mid-READY restarts the clear sequence from address 0. Data written before the reset is lost once the clear completes.
- No arithmetic beyond `clr_cnt`. `clr_cnt` never wraps because the state leaves CLEAR at `DEPTH`-1.

## Timing
- Reset values: `q_a`=0, `q_b`=0, `busy`=1.
- Clear window:
  - Edges 1..`DEPTH` after `rst_n` is first sampled high perform the clears.
  - `busy` is low after edge `DEPTH`.
  - The first accepted write and read occur on edge `DEPTH`+1.
- Read latency is 1 cycle: address on edge N gives `q_x` valid after edge N.
- Write then read of the same address:
  - Read on the next edge returns the new data, regardless of `BYPASS`.
  - Same-edge read returns the new data if `BYPASS`=1, or the old data if `BYPASS`=0.
- `busy` is registered and can be used directly by the controller as a stall.

## Test plan
- Reset and clear, `ADDR_W`=3: hold `rst_n`=0 for 3 cycles, then release.
  - `busy`=1 for exactly 8 edges after release, then 0.
  - Reading all 8 addresses returns 0x00.
- Write/read, both ports: write 0xA5 to address 2 and 0x3C to address 7; next cycle `read_addr_a`=2, `read_addr_b`=7.
  - One cycle later `q_a`=0xA5 and `q_b`=0x3C.
- Bypass, `BYPASS`=1 then `BYPASS`=0: address 4 holds 0x11; in the same cycle `we`=1, `data`=0x77, write address 4, `read_addr_a`=4, `re_a`=1.
  - `BYPASS`=1 gives `q_a`=0x77; `BYPASS`=0 gives `q_a`=0x11.
  - The following read returns 0x77 in both configurations.
- Read-enable hold: `q_b`=0x3C, then `re_b`=0 with `read_addr_b` changed for 5 cycles.
  - `q_b` stays 0x3C.
- Ignored operations while busy: issue `we`=1, address 1, `data`=0xFF during the clear window.
  - After the clear, address 1 reads 0x00 and `q_a`/`q_b` stay 0 throughout the window.
- Mid-clear reset, plus a scaled configuration:
  - Assert `rst_n`=0 at clear edge 4. The full 8-edge clear restarts, and `busy` deasserts 8 edges after the re-release.
  - Repeat the write/read scenario with `DATA_W`=16, `ADDR_W`=4, using 0xBEEF at address 15.
